// File: rtl/sort_sched.sv
// sort_sched -- streaming K-nearest-neighbour controller around an external
// N-wide bitonic-style sorter.
//
// An N-slot buffer holds the best K entries seen so far (slots 0..K-1, the
// "carry") followed by up to N-K freshly accepted samples (slots K..N-1).
// When the new-sample region fills, or the query's last sample arrives, the
// whole buffer is launched into the sorter. The sorted result's first K slots
// become the new carry. After the final batch the carry is presented as the
// query result.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   s_valid/s_ready          sample handshake; s_dist, s_type, s_last payload
//   srt_in_valid             one-cycle sorter launch pulse
//   srt_ascending            tied to 1
//   srt_in, srt_in_type      buffer contents, slot i at [W*(i+1)-1:W*i]
//   srt_out, srt_out_type    sorted buffer from the sorter, slot 0 smallest
//   srt_out_valid            sorter result valid (only honoured while waiting)
//   res_valid/res_ready      result handshake
//   res_dist, res_type       K nearest entries, slot 0 nearest
//   res_count                samples accepted in this query (saturating)
//   err_timeout              sticky: sorter failed to answer within TIMEOUT
module sort_sched #(
  parameter int L       = 5,
  parameter int W       = 16,
  parameter int TYPE_W  = 3,
  parameter int K       = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [W-1:0]             s_dist,
  input  logic [TYPE_W-1:0]        s_type,
  input  logic                     s_last,
  output logic                     srt_in_valid,
  output logic                     srt_ascending,
  output logic [W*(2**L)-1:0]      srt_in,
  output logic [TYPE_W*(2**L)-1:0] srt_in_type,
  input  logic [W*(2**L)-1:0]      srt_out,
  input  logic [TYPE_W*(2**L)-1:0] srt_out_type,
  input  logic                     srt_out_valid,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [W*K-1:0]           res_dist,
  output logic [TYPE_W*K-1:0]      res_type,
  output logic [15:0]              res_count,
  output logic                     err_timeout
);

  localparam int N   = 2**L;
  localparam int CW  = (L < 1) ? 1 : L;
  localparam int TCW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_FILL, S_WAIT, S_RESULT} state_t;

  state_t              r_state, w_next;
  logic [W-1:0]        r_dist [N];
  logic [TYPE_W-1:0]   r_type [N];
  logic [CW-1:0]       r_cnt;
  logic [TCW-1:0]      r_wcnt;
  logic [15:0]         r_res_count;
  logic                r_last;
  logic                r_err;

  logic w_s_hs, w_batch_end, w_tmo;

  assign w_s_hs      = s_valid && s_ready;
  // A batch closes when the new-sample region is full or the query ends.
  assign w_batch_end = (r_cnt == CW'(N-K-1)) || s_last;
  assign w_tmo       = (r_wcnt == TCW'(TIMEOUT-1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_FILL;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FILL:   if (w_s_hs && w_batch_end) w_next = S_WAIT;
      S_WAIT:   if (srt_out_valid)         w_next = r_last ? S_RESULT : S_FILL;
                else if (w_tmo)            w_next = S_FILL;
      S_RESULT: if (res_ready)             w_next = S_FILL;
      default:                             w_next = S_FILL;
    endcase
  end

  // Outputs. s_ready is gated by rst so it stays low through reset cycles.
  always_comb begin
    s_ready      = (r_state == S_FILL) && !rst;
    srt_in_valid = (r_state == S_WAIT) && (r_wcnt == '0);
    res_valid    = (r_state == S_RESULT);
  end

  // Buffer, counters and flags
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        r_dist[i] <= '1;
        r_type[i] <= '0;
      end
      r_cnt       <= '0;
      r_wcnt      <= '0;
      r_res_count <= '0;
      r_last      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        S_FILL: begin
          r_wcnt <= '0;
          if (w_s_hs) begin
            for (int i = 0; i < N-K; i++) begin
              if (r_cnt == CW'(i)) begin
                r_dist[K+i] <= s_dist;
                r_type[K+i] <= s_type;
              end
            end
            r_cnt <= r_cnt + 1'b1;
            if (r_res_count != 16'hFFFF) r_res_count <= r_res_count + 16'd1;
            if (w_batch_end) r_last <= s_last;
          end
        end
        S_WAIT: begin
          if (srt_out_valid) begin
            // Keep the K best, reopen the new-sample region with pads.
            for (int i = 0; i < N; i++) begin
              if (i < K) begin
                r_dist[i] <= srt_out[W*i +: W];
                r_type[i] <= srt_out_type[TYPE_W*i +: TYPE_W];
              end else begin
                r_dist[i] <= '1;
                r_type[i] <= '0;
              end
            end
            r_cnt <= '0;
          end else if (w_tmo) begin
            // Sorter never answered: drop the query entirely.
            for (int i = 0; i < N; i++) begin
              r_dist[i] <= '1;
              r_type[i] <= '0;
            end
            r_cnt       <= '0;
            r_res_count <= '0;
            r_last      <= 1'b0;
            r_err       <= 1'b1;
          end else begin
            r_wcnt <= r_wcnt + 1'b1;
          end
        end
        S_RESULT: begin
          if (res_ready) begin
            for (int i = 0; i < K; i++) begin
              r_dist[i] <= '1;
              r_type[i] <= '0;
            end
            r_res_count <= '0;
            r_last      <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Pack buffer onto the flat sorter / result buses
  always_comb begin
    srt_in      = '0;
    srt_in_type = '0;
    res_dist    = '0;
    res_type    = '0;
    for (int i = 0; i < N; i++) begin
      srt_in[W*i +: W]                = r_dist[i];
      srt_in_type[TYPE_W*i +: TYPE_W] = r_type[i];
    end
    for (int i = 0; i < K; i++) begin
      res_dist[W*i +: W]           = r_dist[i];
      res_type[TYPE_W*i +: TYPE_W] = r_type[i];
    end
  end

  assign srt_ascending = 1'b1;
  assign res_count     = r_res_count;
  assign err_timeout   = r_err;

  // Sorted slots beyond the carry are discarded by design.
  logic w_unused;
  assign w_unused = ^{srt_out[W*N-1:W*K], srt_out_type[TYPE_W*N-1:TYPE_W*K]};

endmodule

// File: tb/tb_sort_sched.sv
module tb_sort_sched;
  localparam int L = 3, N = 8, W = 8, TW = 3, K = 3, TMO = 16;

  logic clk = 0, rst;
  logic s_valid, s_ready, s_last;
  logic [W-1:0] s_dist;
  logic [TW-1:0] s_type;
  logic srt_in_valid, srt_ascending, srt_out_valid;
  logic [W*N-1:0] srt_in, srt_out;
  logic [TW*N-1:0] srt_in_type, srt_out_type;
  logic res_valid, res_ready, err_timeout;
  logic [W*K-1:0] res_dist;
  logic [TW*K-1:0] res_type;
  logic [15:0] res_count;

  always #5 clk = ~clk;

  sort_sched #(.L(L), .W(W), .TYPE_W(TW), .K(K), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
    .s_dist(s_dist), .s_type(s_type), .s_last(s_last),
    .srt_in_valid(srt_in_valid), .srt_ascending(srt_ascending),
    .srt_in(srt_in), .srt_in_type(srt_in_type),
    .srt_out(srt_out), .srt_out_type(srt_out_type), .srt_out_valid(srt_out_valid),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_dist(res_dist), .res_type(res_type), .res_count(res_count),
    .err_timeout(err_timeout));

  int compared = 0, mismatched = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Sorter model: stable ascending sort, answers 3 edges after launch.
  function automatic logic [TW*N+W*N-1:0] sortm(input logic [W*N-1:0] d, input logic [TW*N-1:0] t);
    int dd [N];
    int tt [N];
    int kd, kt, j;
    logic [W*N-1:0] od;
    logic [TW*N-1:0] ot;
    for (int i = 0; i < N; i++) begin
      dd[i] = int'(d[W*i +: W]);
      tt[i] = int'(t[TW*i +: TW]);
    end
    for (int i = 1; i < N; i++) begin
      kd = dd[i]; kt = tt[i]; j = i - 1;
      while (j >= 0 && dd[j] > kd) begin
        dd[j+1] = dd[j]; tt[j+1] = tt[j]; j--;
      end
      dd[j+1] = kd; tt[j+1] = kt;
    end
    od = '0; ot = '0;
    for (int i = 0; i < N; i++) begin
      od[W*i +: W] = W'(dd[i]);
      ot[TW*i +: TW] = TW'(tt[i]);
    end
    return {ot, od};
  endfunction

  logic model_en;
  int dly = 0;
  int pulses = 0;
  logic in_wait = 0;
  int viol = 0;

  always @(posedge clk) begin
    srt_out_valid <= 1'b0;
    if (srt_out_valid || rst) in_wait <= 1'b0;
    if (srt_in_valid) pulses <= pulses + 1;
    if (dly > 0) begin
      dly <= dly - 1;
      if (dly == 1) srt_out_valid <= 1'b1;
    end
    if (srt_in_valid && model_en) begin
      {srt_out_type, srt_out} <= sortm(srt_in, srt_in_type);
      dly <= 3;
      in_wait <= 1'b1;
    end
  end

  always @(negedge clk) if (in_wait && s_ready) viol <= viol + 1;

  task automatic send(input logic [W-1:0] d, input logic [TW-1:0] t, input logic last);
    int n = 0;
    s_valid = 1; s_dist = d; s_type = t; s_last = last;
    while (!s_ready && n < 200) begin @(negedge clk); n++; end
    if (!s_ready) chk("s_ready_wait", 0, 1);
    @(negedge clk);
    s_valid = 0; s_last = 0;
  endtask

  task automatic wait_res();
    int n = 0;
    while (!res_valid && n < 300) begin @(negedge clk); n++; end
    chk("res_valid_wait", res_valid, 1);
  endtask

  task automatic consume();
    res_ready = 1;
    @(negedge clk);
    res_ready = 0;
  endtask

  typedef struct {
    int n;
    logic [11:0][W-1:0] d;
    logic [11:0][TW-1:0] t;
    logic [K-1:0][W-1:0] ed;
    logic [K-1:0][TW-1:0] et;
    int ecnt;
    int epulse;
  } vec_t;

  vec_t vecs [5];

  initial begin
    logic [W*K-1:0] hd;
    logic [TW*K-1:0] ht;
    int stable_bad;
    int n;

    // v0: basic three-sample query
    vecs[0].n = 3;
    vecs[0].d[0] = 40; vecs[0].t[0] = 1;
    vecs[0].d[1] = 10; vecs[0].t[1] = 2;
    vecs[0].d[2] = 30; vecs[0].t[2] = 3;
    vecs[0].ed = {8'd40, 8'd30, 8'd10}; vecs[0].et = {3'd1, 3'd3, 3'd2};
    vecs[0].ecnt = 3; vecs[0].epulse = 1;
    // v1: fewer than K samples -> trailing pad
    vecs[1].n = 2;
    vecs[1].d[0] = 20; vecs[1].t[0] = 1;
    vecs[1].d[1] = 5;  vecs[1].t[1] = 2;
    vecs[1].ed = {8'd255, 8'd20, 8'd5}; vecs[1].et = {3'd0, 3'd1, 3'd2};
    vecs[1].ecnt = 2; vecs[1].epulse = 1;
    // v2: 12 descending samples -> batches 5,5,2
    vecs[2].n = 12;
    for (int i = 0; i < 12; i++) begin
      vecs[2].d[i] = W'(12 - i); vecs[2].t[i] = TW'(i);
    end
    vecs[2].ed = {8'd3, 8'd2, 8'd1}; vecs[2].et = {3'd1, 3'd2, 3'd3};
    vecs[2].ecnt = 12; vecs[2].epulse = 3;
    // v3: last coincides with full batch; tie keeps sorter order
    vecs[3].n = 5;
    vecs[3].d[0] = 50; vecs[3].t[0] = 1;
    vecs[3].d[1] = 60; vecs[3].t[1] = 2;
    vecs[3].d[2] = 45; vecs[3].t[2] = 3;
    vecs[3].d[3] = 70; vecs[3].t[3] = 4;
    vecs[3].d[4] = 45; vecs[3].t[4] = 5;
    vecs[3].ed = {8'd50, 8'd45, 8'd45}; vecs[3].et = {3'd1, 3'd5, 3'd3};
    vecs[3].ecnt = 5; vecs[3].epulse = 1;
    // v4: full batch then one trailing sample
    vecs[4].n = 6;
    for (int i = 0; i < 5; i++) begin
      vecs[4].d[i] = W'(9 - i); vecs[4].t[i] = TW'(i + 1);
    end
    vecs[4].d[5] = 100; vecs[4].t[5] = 6;
    vecs[4].ed = {8'd7, 8'd6, 8'd5}; vecs[4].et = {3'd3, 3'd4, 3'd5};
    vecs[4].ecnt = 6; vecs[4].epulse = 2;

    rst = 1; s_valid = 0; s_dist = 0; s_type = 0; s_last = 0; res_ready = 0;
    model_en = 1;
    repeat (2) @(negedge clk);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_srt_in_valid", srt_in_valid, 0);
    chk("rst_err", err_timeout, 0);
    chk("rst_count", res_count, 0);
    chk("rst_srt_in", srt_in, {64{1'b1}});
    chk("rst_srt_in_type", srt_in_type, 0);
    chk("ascending", srt_ascending, 1);
    rst = 0;
    @(negedge clk);
    chk("s_ready_after_rst", s_ready, 1);

    // Table-driven queries
    for (int v = 0; v < 5; v++) begin
      pulses = 0; viol = 0;
      for (int i = 0; i < vecs[v].n; i++)
        send(vecs[v].d[i], vecs[v].t[i], i == vecs[v].n - 1);
      wait_res();
      chk($sformatf("v%0d_dist", v), res_dist, vecs[v].ed);
      chk($sformatf("v%0d_type", v), res_type, vecs[v].et);
      chk($sformatf("v%0d_count", v), res_count, vecs[v].ecnt);
      chk($sformatf("v%0d_pulses", v), pulses, vecs[v].epulse);
      chk($sformatf("v%0d_no_ready_in_wait", v), viol, 0);
      consume();
      chk($sformatf("v%0d_res_valid_clr", v), res_valid, 0);
      chk($sformatf("v%0d_count_clr", v), res_count, 0);
    end

    // Backpressure: result held stable for 10 cycles
    send(20, 1, 0); send(5, 2, 1);
    wait_res();
    hd = res_dist; ht = res_type; stable_bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (!res_valid || s_ready || res_dist !== hd || res_type !== ht) stable_bad++;
    end
    chk("hold_stable", stable_bad, 0);
    chk("hold_dist", hd, {8'd255, 8'd20, 8'd5});
    consume();
    send(30, 4, 1);
    wait_res();
    chk("after_hold_dist", res_dist, {8'd255, 8'd255, 8'd30});
    chk("after_hold_type", res_type, {3'd0, 3'd0, 3'd4});
    chk("after_hold_count", res_count, 1);
    consume();

    // Sorter timeout
    model_en = 0;
    send(7, 1, 1);
    chk("tmo_err_early", err_timeout, 0);
    chk("tmo_s_ready_early", s_ready, 0);
    repeat (15) @(negedge clk);
    chk("tmo_err_edge", err_timeout, 0);
    @(negedge clk);
    chk("tmo_err_set", err_timeout, 1);
    chk("tmo_s_ready", s_ready, 1);
    chk("tmo_count_clr", res_count, 0);
    chk("tmo_srt_in_pad", srt_in, {64{1'b1}});
    model_en = 1;
    send(40, 1, 0); send(10, 2, 0); send(30, 3, 1);
    wait_res();
    chk("post_tmo_dist", res_dist, {8'd40, 8'd30, 8'd10});
    chk("post_tmo_type", res_type, {3'd1, 3'd3, 3'd2});
    chk("post_tmo_err_sticky", err_timeout, 1);
    consume();

    // Reset during WAIT; late sorter answer must be ignored
    send(20, 1, 0);
    s_valid = 1; s_dist = 5; s_type = 2; s_last = 1;
    n = 0;
    while (!srt_in_valid && n < 50) begin @(negedge clk); n++; end
    s_valid = 0; s_last = 0;
    chk("rstw_launch", srt_in_valid, 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    stable_bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (res_valid) stable_bad++;
    end
    chk("rstw_no_result", stable_bad, 0);
    chk("rstw_s_ready", s_ready, 1);
    chk("rstw_count", res_count, 0);
    chk("rstw_err_clr", err_timeout, 0);
    send(9, 6, 1);
    wait_res();
    chk("rstw_next_dist", res_dist, {8'd255, 8'd255, 8'd9});
    chk("rstw_next_count", res_count, 1);
    consume();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
